// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported fixed-latency memory between fetch (IF) and data (MEM) ports
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-low reset
//   if_req     in   fetch request, held with if_addr until if_ready
//   if_addr    in   [31:0] fetch address
//   if_rdata   out  [31:0] fetched word, valid only while if_ready
//   if_ready   out  one-cycle fetch completion strobe
//   d_req      in   data request, held with d_we/d_addr/d_wdata until d_ready
//   d_we       in   1=store, 0=load
//   d_addr     in   [31:0] data address
//   d_wdata    in   [31:0] store data
//   d_rdata    out  [31:0] load data, valid only while d_ready and !d_we
//   d_ready    out  one-cycle data completion strobe
//   mem_en     out  memory access enable
//   mem_we     out  memory write enable (only with mem_en)
//   mem_addr   out  [31:0] memory address
//   mem_wdata  out  [31:0] memory write data
//   mem_rdata  in   [31:0] memory read data, valid in the last beat of an access
//   stall_if   out  fetch waiting (if_req & ~if_ready)
//   stall_mem  out  data waiting (d_req & ~d_ready)
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_mem
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;
    localparam int BW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [BW-1:0] LAST = BW'(MEM_LAT - 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
    logic [1:0]    state;
    logic [BW-1:0] beat;
    logic [SW-1:0] starve;
    logic          is_i, is_d, done, decide, i_cand, d_cand, grant_i, grant_d;
    always_comb begin
        is_i      = state == BUSY_I;
        is_d      = state == BUSY_D;
        // every output is gated by reset so nothing leaks while it is held low
        mem_en    = reset && (is_i || is_d);
        done      = mem_en && beat == LAST;
        if_ready  = done && is_i;
        d_ready   = done && is_d;
        mem_we    = mem_en && is_d && d_we;
        mem_addr  = mem_en ? (is_d ? d_addr : if_addr) : 32'd0;
        mem_wdata = (mem_en && is_d) ? d_wdata : 32'd0;
        if_rdata  = if_ready ? mem_rdata : 32'd0;
        d_rdata   = (d_ready && !d_we) ? mem_rdata : 32'd0;
        // the port completing this cycle still has its request up; it must not be re-granted
        i_cand    = if_req && !if_ready;
        d_cand    = d_req && !d_ready;
        stall_if  = reset && i_cand;
        stall_mem = reset && d_cand;
        decide    = reset && (state == IDLE || done);
        grant_i   = decide && i_cand && (!d_cand || starve == SMAX);
        grant_d   = decide && d_cand && !grant_i;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            beat   <= '0;
            starve <= '0;
        end else if (grant_d) begin
            state <= BUSY_D;
            beat  <= '0;
            if (if_req && starve != SMAX)
                starve <= starve + 1'b1;
        end else if (grant_i) begin
            state  <= BUSY_I;
            beat   <= '0;
            starve <= '0;
        end else if (done) begin
            state <= IDLE;
            beat  <= '0;
        end else if (mem_en) begin
            beat <= beat + 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter (MEM_LAT=2 and MEM_LAT=1 instances)
module tb_mem_port_arbiter;
    logic        clk = 1'b0, reset = 1'b0, if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ready, d_ready, mem_en, mem_we, stall_if, stall_mem;
    logic [31:0] l1_if_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata;
    logic        l1_if_ready, l1_d_ready, l1_mem_en, l1_mem_we, l1_stall_if, l1_stall_mem;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) u0 (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u1 (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_rdata(l1_if_rdata),
        .if_ready(l1_if_ready), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(l1_d_rdata), .d_ready(l1_d_ready), .mem_en(l1_mem_en), .mem_we(l1_mem_we),
        .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata), .mem_rdata(mem_rdata),
        .stall_if(l1_stall_if), .stall_mem(l1_stall_mem)
    );

    task automatic drain;
        logic ok;
        ok = 1'b0;
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            ok = !mem_en && !l1_mem_en;
        end
        n_chk++; if (!ok) begin n_fail++; $display("FAIL drain_timeout: mem_en=%b l1_mem_en=%b want 0", mem_en, l1_mem_en); end
    endtask

    task automatic test_reset;
        reset = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        if_addr = 32'h0040_0000; d_addr = 32'h1001_0000; d_wdata = 32'h0BAD_F00D; mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            n_chk++; if ({mem_en, mem_we, if_ready, d_ready, stall_if, stall_mem} !== 6'b0 || {mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'b0) begin
                n_fail++; $display("FAIL reset_outputs: ctl=%b addr=%h wdata=%h if_rdata=%h d_rdata=%h want all 0",
                    {mem_en, mem_we, if_ready, d_ready, stall_if, stall_mem}, mem_addr, mem_wdata, if_rdata, d_rdata);
            end
        end
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        n_chk++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rel_c1_mem_en: got %b want 0", mem_en); end
        n_chk++; if ({stall_if, stall_mem} !== 2'b11) begin n_fail++; $display("FAIL rel_c1_stall: got %b want 11", {stall_if, stall_mem}); end
        @(negedge clk);
        n_chk++; if (mem_en !== 1'b1 || mem_addr !== 32'h1001_0000) begin n_fail++; $display("FAIL rel_c2_grant: en=%b addr=%h want 1 10010000", mem_en, mem_addr); end
        @(negedge clk);
        n_chk++; if (d_ready !== 1'b1 || d_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rel_c3_dready: rdy=%b rdata=%h want 1 ffffffff", d_ready, d_rdata); end
        drain();
    endtask

    task automatic test_lone_fetch;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h0040_0000; mem_rdata = 32'h2008_0005;
        @(negedge clk);
        n_chk++; if ({stall_if, mem_en} !== 2'b10) begin n_fail++; $display("FAIL fetch_t0: stall_if,mem_en=%b want 10", {stall_if, mem_en}); end
        @(negedge clk);
        n_chk++; if ({mem_en, mem_we, if_ready, stall_if} !== 4'b1001 || mem_addr !== 32'h0040_0000 || if_rdata !== 32'd0) begin
            n_fail++; $display("FAIL fetch_t1: en,we,rdy,stall=%b addr=%h rdata=%h want 1001 00400000 0", {mem_en, mem_we, if_ready, stall_if}, mem_addr, if_rdata);
        end
        @(negedge clk);
        n_chk++; if ({mem_en, if_ready, stall_if} !== 3'b110 || if_rdata !== 32'h2008_0005) begin
            n_fail++; $display("FAIL fetch_t2: en,rdy,stall=%b rdata=%h want 110 20080005", {mem_en, if_ready, stall_if}, if_rdata);
        end
        @(posedge clk); #1 if_req = 1'b0;
        @(negedge clk);
        n_chk++; if ({mem_en, if_ready} !== 2'b00) begin n_fail++; $display("FAIL fetch_t3_idle: en,rdy=%b want 00", {mem_en, if_ready}); end
        drain();
    endtask

    task automatic test_priority;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h0040_0004; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0004; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        n_chk++; if ({mem_en, stall_if, stall_mem} !== 3'b011) begin n_fail++; $display("FAIL prio_c0: en,sif,smem=%b want 011", {mem_en, stall_if, stall_mem}); end
        @(negedge clk);
        n_chk++; if (mem_en !== 1'b1 || mem_addr !== 32'h1001_0004) begin n_fail++; $display("FAIL prio_c1_data: en=%b addr=%h want 1 10010004", mem_en, mem_addr); end
        @(negedge clk);
        n_chk++; if ({d_ready, if_ready} !== 2'b10 || d_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL prio_c2_dready: d,i=%b rdata=%h want 10 12345678", {d_ready, if_ready}, d_rdata); end
        @(posedge clk); #1 d_req = 1'b0;
        @(negedge clk);
        n_chk++; if (mem_en !== 1'b1 || mem_addr !== 32'h0040_0004 || d_ready !== 1'b0) begin n_fail++; $display("FAIL prio_c3_fetch: en=%b addr=%h drdy=%b want 1 00400004 0", mem_en, mem_addr, d_ready); end
        @(negedge clk);
        n_chk++; if (if_ready !== 1'b1 || if_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL prio_c4_iready: rdy=%b rdata=%h want 1 12345678", if_ready, if_rdata); end
        drain();
    endtask

    task automatic test_store;
        int pulses;
        pulses = 0;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0008; d_wdata = 32'hDEAD_BEEF; mem_rdata = 32'h5555_5555;
        @(negedge clk);
        @(negedge clk);
        pulses += int'(d_ready);
        n_chk++; if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 32'h1001_0008 || mem_wdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL store_b0: en,we=%b addr=%h wdata=%h want 11 10010008 deadbeef", {mem_en, mem_we}, mem_addr, mem_wdata);
        end
        @(negedge clk);
        pulses += int'(d_ready);
        n_chk++; if ({mem_we, d_ready} !== 2'b11 || mem_wdata !== 32'hDEAD_BEEF || d_rdata !== 32'd0) begin
            n_fail++; $display("FAIL store_b1: we,rdy=%b wdata=%h rdata=%h want 11 deadbeef 0", {mem_we, d_ready}, mem_wdata, d_rdata);
        end
        @(posedge clk); #1 d_req = 1'b0;
        @(negedge clk);
        pulses += int'(d_ready);
        n_chk++; if ({mem_en, mem_we} !== 2'b00) begin n_fail++; $display("FAIL store_after: en,we=%b want 00", {mem_en, mem_we}); end
        n_chk++; if (pulses !== 1) begin n_fail++; $display("FAIL store_ready_count: got %0d want 1", pulses); end
        drain();
    endtask

    task automatic test_drop;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_000C; mem_rdata = 32'hCAFE_0001;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL drop_b0: en=%b want 1", mem_en); end
        @(posedge clk); #1 d_req = 1'b0;
        @(negedge clk);
        n_chk++; if ({d_ready, stall_mem} !== 2'b10 || d_rdata !== 32'hCAFE_0001) begin n_fail++; $display("FAIL drop_ready: rdy,stall=%b rdata=%h want 10 cafe0001", {d_ready, stall_mem}, d_rdata); end
        drain();
    endtask

    task automatic test_starvation;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; if_addr = 32'h0040_0100; mem_rdata = 32'h0000_0077;
        for (int k = 0; k < 4; k++) begin
            d_addr = 32'h1001_0100 + 32'(4 * k); if_req = 1'b1;
            @(negedge clk);
            n_chk++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL starve_idle%0d: en=%b want 0", k, mem_en); end
            @(posedge clk); #1 if_req = 1'b0;
            @(negedge clk);
            n_chk++; if (mem_en !== 1'b1 || mem_addr !== 32'h1001_0100 + 32'(4 * k)) begin n_fail++; $display("FAIL starve_dgrant%0d: en=%b addr=%h want 1 %h", k, mem_en, mem_addr, 32'h1001_0100 + 32'(4 * k)); end
            @(negedge clk);
            n_chk++; if (d_ready !== 1'b1) begin n_fail++; $display("FAIL starve_dready%0d: got %b want 1", k, d_ready); end
            @(posedge clk); #1;
        end
        if_req = 1'b1; d_addr = 32'h1001_0200;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0040_0100) begin n_fail++; $display("FAIL starve_forced_fetch: en=%b we=%b addr=%h want 1 0 00400100", mem_en, mem_we, mem_addr); end
        @(negedge clk);
        n_chk++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL starve_iready: got %b want 1", if_ready); end
        @(posedge clk); #1 if_req = 1'b0;
        @(negedge clk);
        n_chk++; if (mem_en !== 1'b1 || mem_addr !== 32'h1001_0200) begin n_fail++; $display("FAIL starve_data_after: en=%b addr=%h want 1 10010200", mem_en, mem_addr); end
        drain();
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0010; mem_rdata = 32'h0000_0099;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL rmid_beat0: en=%b want 1", mem_en); end
        #1 reset = 1'b0;
        @(negedge clk);
        n_chk++; if ({mem_en, d_ready} !== 2'b00) begin n_fail++; $display("FAIL rmid_abort: en,rdy=%b want 00", {mem_en, d_ready}); end
        @(posedge clk); #1;
        reset = 1'b1; d_req = 1'b0;
        @(negedge clk);
        n_chk++; if ({mem_en, d_ready} !== 2'b00) begin n_fail++; $display("FAIL rmid_release: en,rdy=%b want 00", {mem_en, d_ready}); end
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h0040_0010;
        @(negedge clk);
        n_chk++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rmid_idle: en=%b want 0", mem_en); end
        @(negedge clk);
        n_chk++; if (mem_en !== 1'b1 || mem_addr !== 32'h0040_0010) begin n_fail++; $display("FAIL rmid_regrant: en=%b addr=%h want 1 00400010", mem_en, mem_addr); end
        drain();
    endtask

    task automatic test_lat1;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h0040_0020; mem_rdata = 32'h0000_00A5;
        @(negedge clk);
        n_chk++; if ({l1_mem_en, l1_stall_if} !== 2'b01) begin n_fail++; $display("FAIL lat1_t0: en,stall=%b want 01", {l1_mem_en, l1_stall_if}); end
        @(negedge clk);
        n_chk++; if ({l1_mem_en, l1_if_ready} !== 2'b11 || l1_if_rdata !== 32'h0000_00A5 || l1_mem_addr !== 32'h0040_0020) begin
            n_fail++; $display("FAIL lat1_fetch: en,rdy=%b rdata=%h addr=%h want 11 000000a5 00400020", {l1_mem_en, l1_if_ready}, l1_if_rdata, l1_mem_addr);
        end
        @(posedge clk); #1 if_req = 1'b0;
        @(negedge clk);
        n_chk++; if ({l1_mem_en, l1_if_ready} !== 2'b00) begin n_fail++; $display("FAIL lat1_no_double: en,rdy=%b want 00", {l1_mem_en, l1_if_ready}); end
        drain();
        @(posedge clk); #1;
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0020;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (l1_d_ready !== 1'b1 || l1_mem_addr !== 32'h1001_0020) begin n_fail++; $display("FAIL lat1_data: rdy=%b addr=%h want 1 10010020", l1_d_ready, l1_mem_addr); end
        @(posedge clk); #1 d_req = 1'b0;
        @(negedge clk);
        n_chk++; if (l1_if_ready !== 1'b1 || l1_mem_addr !== 32'h0040_0020) begin n_fail++; $display("FAIL lat1_b2b_fetch: rdy=%b addr=%h want 1 00400020", l1_if_ready, l1_mem_addr); end
        drain();
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_priority();
        test_store();
        test_drop();
        test_starvation();
        test_reset_mid();
        test_lat1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
